// File: rtl/vec_io_buff.sv
// Vector I/O buffer: loads N elements from a narrow byte bus (one element per slot,
// or one scalar broadcast to every slot) and serialises a parallel vector back out.
module vec_io_buff #(
  parameter int N      = 16,
  parameter int ELEM_W = 8,
  parameter int BUS_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_W-1:0]      in_bus,
  input  logic                  in_valid,
  output logic [BUS_W-1:0]      out_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  start_load_vec,
  input  logic                  start_load_scal,
  input  logic                  start_unload,
  input  logic                  abort,
  input  logic [N*ELEM_W-1:0]   par_in,
  output logic [N*ELEM_W-1:0]   par_out,
  output logic                  vec_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BEATS = ELEM_W / BUS_W;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW = $clog2(N);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);
  localparam logic [EW-1:0] ELEM_ONE  = EW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_VEC  = 2'd1,
    LOAD_SCAL = 2'd2,
    UNLOAD    = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [EW-1:0]         elem_cnt_r, elem_cnt_s;
  logic [BW-1:0]         beat_cnt_r, beat_cnt_s;
  logic [N*ELEM_W-1:0]   storage_r, storage_s;
  logic [ELEM_W-1:0]     scal_r, scal_s;
  logic                  vec_valid_r, vec_valid_s;
  logic                  done_r, done_s;
  logic                  busy_r, out_valid_r;
  logic                  last_beat_s, last_elem_s;
  int unsigned           off_s, beat_off_s;

  // Bit offset of the beat currently addressed by the counters.
  assign beat_off_s  = 32'(beat_cnt_r) * BUS_W;
  assign off_s       = 32'(elem_cnt_r) * ELEM_W + beat_off_s;
  assign last_beat_s = (beat_cnt_r == BEAT_LAST);
  assign last_elem_s = (elem_cnt_r == ELEM_LAST);

  assign par_out   = storage_r;
  assign out_bus   = storage_r[off_s +: BUS_W];
  assign out_valid = out_valid_r;
  assign vec_valid = vec_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Next-state, counter and storage update logic.
  always_comb begin
    state_s     = state_r;
    elem_cnt_s  = elem_cnt_r;
    beat_cnt_s  = beat_cnt_r;
    storage_s   = storage_r;
    scal_s      = scal_r;
    vec_valid_s = vec_valid_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_load_vec) begin
          state_s     = LOAD_VEC;
          elem_cnt_s  = '0;
          beat_cnt_s  = '0;
          vec_valid_s = 1'b0;
        end else if (start_load_scal) begin
          state_s     = LOAD_SCAL;
          elem_cnt_s  = '0;
          beat_cnt_s  = '0;
          vec_valid_s = 1'b0;
        end else if (start_unload) begin
          state_s     = UNLOAD;
          elem_cnt_s  = '0;
          beat_cnt_s  = '0;
          vec_valid_s = 1'b0;
          storage_s   = par_in;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_VEC: begin
        if (abort) begin
          state_s     = IDLE;
          vec_valid_s = 1'b0;
        end else if (in_valid) begin
          storage_s[off_s +: BUS_W] = in_bus;
          if (last_beat_s) begin
            beat_cnt_s = '0;
            if (last_elem_s) begin
              state_s     = IDLE;
              elem_cnt_s  = '0;
              vec_valid_s = 1'b1;
              done_s      = 1'b1;
            end else begin
              elem_cnt_s = elem_cnt_r + ELEM_ONE;
            end
          end else begin
            beat_cnt_s = beat_cnt_r + BEAT_ONE;
          end
        end else begin
          state_s = LOAD_VEC;
        end
      end
      LOAD_SCAL: begin
        if (abort) begin
          state_s     = IDLE;
          vec_valid_s = 1'b0;
        end else if (in_valid) begin
          scal_s[beat_off_s +: BUS_W] = in_bus;
          if (last_beat_s) begin
            // Broadcast uses the freshly assembled scalar, including this beat.
            for (int i = 0; i < N; i++) begin
              storage_s[i*ELEM_W +: ELEM_W] = scal_s;
            end
            beat_cnt_s  = '0;
            state_s     = IDLE;
            vec_valid_s = 1'b1;
            done_s      = 1'b1;
          end else begin
            beat_cnt_s = beat_cnt_r + BEAT_ONE;
          end
        end else begin
          state_s = LOAD_SCAL;
        end
      end
      UNLOAD: begin
        if (abort) begin
          state_s     = IDLE;
          vec_valid_s = 1'b0;
        end else if (out_ready) begin
          if (last_beat_s) begin
            beat_cnt_s = '0;
            if (last_elem_s) begin
              state_s    = IDLE;
              elem_cnt_s = '0;
              done_s     = 1'b1;
            end else begin
              elem_cnt_s = elem_cnt_r + ELEM_ONE;
            end
          end else begin
            beat_cnt_s = beat_cnt_r + BEAT_ONE;
          end
        end else begin
          state_s = UNLOAD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      elem_cnt_r  <= '0;
      beat_cnt_r  <= '0;
      storage_r   <= '0;
      scal_r      <= '0;
      vec_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      elem_cnt_r  <= elem_cnt_s;
      beat_cnt_r  <= beat_cnt_s;
      storage_r   <= storage_s;
      scal_r      <= scal_s;
      vec_valid_r <= vec_valid_s;
      done_r      <= done_s;
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_s == UNLOAD);
    end
  end

endmodule

// File: tb/tb_vec_io_buff.sv
// Directed bench for vec_io_buff (N=4, ELEM_W=16, BUS_W=8): per-cycle vector table
// for vector/scalar loads plus hand sequences for unload, abort, priority and reset.
module tb_vec_io_buff;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_valid, out_ready;
  logic        start_load_vec, start_load_scal, start_unload, abort;
  logic        vec_valid, busy, done;
  logic [7:0]  in_bus, out_bus;
  logic [63:0] par_in, par_out;
  int          n_cmp = 0;
  int          n_err = 0;

  vec_io_buff #(.N(4), .ELEM_W(16), .BUS_W(8)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .in_valid(in_valid),
    .out_bus(out_bus), .out_valid(out_valid), .out_ready(out_ready),
    .start_load_vec(start_load_vec), .start_load_scal(start_load_scal),
    .start_unload(start_unload), .abort(abort), .par_in(par_in),
    .par_out(par_out), .vec_valid(vec_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       slv, sls, su, ab, iv;
    logic [7:0] ib;
    logic       e_busy, e_done, e_vv;
    logic [63:0] e_par;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic slv, sls, su, ab, iv, input logic [7:0] ib,
                     input logic e_busy, e_done, e_vv, input logic [63:0] e_par);
    vec_t v;
    v = '{slv, sls, su, ab, iv, ib, e_busy, e_done, e_vv, e_par};
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    start_load_vec = 1'b0; start_load_scal = 1'b0; start_unload = 1'b0;
    abort = 1'b0; in_valid = 1'b0; in_bus = 8'h00; out_ready = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic b, d, vv, ov);
    chk({tag, ".busy"}, {63'd0, busy}, {63'd0, b});
    chk({tag, ".done"}, {63'd0, done}, {63'd0, d});
    chk({tag, ".vec_valid"}, {63'd0, vec_valid}, {63'd0, vv});
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
  endtask

  task automatic load_beat(input logic [7:0] b);
    in_valid = 1'b1; in_bus = b;
    step();
    in_valid = 1'b0;
  endtask

  logic [7:0] exp_seq [8];
  logic [7:0] seq_b [8];

  initial begin
    idle_in();
    rst = 1'b1;
    par_in = 64'h0;
    step(); step();
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.par_out", par_out, 64'h0);
    rst = 1'b0;

    // Vector load with a gap, stray starts mid-load, then scalar broadcast.
    add(1,0,0,0,0,8'h00, 1,0,0, 64'h0);
    add(0,0,0,0,1,8'h01, 1,0,0, 64'h0000_0000_0000_0001);
    add(0,0,0,0,1,8'h00, 1,0,0, 64'h0000_0000_0000_0001);
    add(0,0,0,0,0,8'hFF, 1,0,0, 64'h0000_0000_0000_0001);
    add(0,0,0,0,1,8'h02, 1,0,0, 64'h0000_0000_0002_0001);
    add(0,1,1,0,1,8'h00, 1,0,0, 64'h0000_0000_0002_0001);
    add(0,0,0,0,1,8'h03, 1,0,0, 64'h0000_0003_0002_0001);
    add(0,0,0,0,1,8'h00, 1,0,0, 64'h0000_0003_0002_0001);
    add(0,0,0,0,1,8'h04, 1,0,0, 64'h0004_0003_0002_0001);
    add(0,0,0,0,1,8'h00, 0,1,1, 64'h0004_0003_0002_0001);
    add(0,0,0,0,0,8'h00, 0,0,1, 64'h0004_0003_0002_0001);
    add(0,1,0,0,0,8'h00, 1,0,0, 64'h0004_0003_0002_0001);
    add(0,0,0,0,1,8'h34, 1,0,0, 64'h0004_0003_0002_0001);
    add(0,0,0,0,1,8'h12, 0,1,1, 64'h1234_1234_1234_1234);
    add(0,0,0,1,0,8'h00, 0,0,1, 64'h1234_1234_1234_1234);
    for (int i = 0; i < tbl.size(); i++) begin
      start_load_vec = tbl[i].slv; start_load_scal = tbl[i].sls;
      start_unload = tbl[i].su; abort = tbl[i].ab;
      in_valid = tbl[i].iv; in_bus = tbl[i].ib; out_ready = 1'b0;
      step();
      chk_flags($sformatf("tbl%0d", i), tbl[i].e_busy, tbl[i].e_done, tbl[i].e_vv, 1'b0);
      chk($sformatf("tbl%0d.par_out", i), par_out, tbl[i].e_par);
    end
    idle_in();

    // Unload with alternating backpressure.
    par_in = 64'hDD04_CC03_BB02_AA01;
    exp_seq = '{8'h01, 8'hAA, 8'h02, 8'hBB, 8'h03, 8'hCC, 8'h04, 8'hDD};
    start_unload = 1'b1;
    step();
    start_unload = 1'b0;
    chk_flags("unl.start", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("unl.par_out", par_out, 64'hDD04_CC03_BB02_AA01);
    for (int k = 0; k < 8; k++) begin
      out_ready = 1'b0;
      step();
      chk($sformatf("unl.hold%0d", k), {56'd0, out_bus}, {56'd0, exp_seq[k]});
      chk($sformatf("unl.ov%0d", k), {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      #1;
      chk($sformatf("unl.bus%0d", k), {56'd0, out_bus}, {56'd0, exp_seq[k]});
      chk($sformatf("unl.nodone%0d", k), {63'd0, done}, 64'd0);
      step();
    end
    out_ready = 1'b0;
    chk_flags("unl.end", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_flags("unl.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Priority: vector load wins over unload, then back-to-back unload, then abort it.
    seq_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_load_vec = 1'b1; start_unload = 1'b1;
    step();
    start_load_vec = 1'b0; start_unload = 1'b0;
    chk_flags("prio", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) load_beat(seq_b[k]);
    chk_flags("prio.done", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("prio.par_out", par_out, 64'h8877_6655_4433_2211);
    start_unload = 1'b1;
    step();
    start_unload = 1'b0;
    chk_flags("b2b", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b.bus", {56'd0, out_bus}, 64'h01);
    out_ready = 1'b1;
    step();
    chk("b2b.bus1", {56'd0, out_bus}, 64'hAA);
    abort = 1'b1;
    step();
    abort = 1'b0; out_ready = 1'b0;
    chk_flags("unl.abort", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_flags("unl.abort2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort on the third beat of a vector load, then a clean reload.
    start_load_vec = 1'b1;
    step();
    start_load_vec = 1'b0;
    load_beat(8'hAB);
    load_beat(8'hCD);
    abort = 1'b1; in_valid = 1'b1; in_bus = 8'hEF;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk_flags("ld.abort", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld.abort.par", par_out, 64'hDD04_CC03_BB02_CDAB);
    step();
    chk_flags("ld.abort2", 1'b0, 1'b0, 1'b0, 1'b0);
    start_load_vec = 1'b1;
    step();
    start_load_vec = 1'b0;
    for (int k = 1; k <= 8; k++) load_beat(8'(k));
    chk_flags("reload", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("reload.par", par_out, 64'h0807_0605_0403_0201);

    // Reset after three accepted unload beats.
    step();
    par_in = 64'hDD04_CC03_BB02_AA01;
    start_unload = 1'b1;
    step();
    start_unload = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("rst.bus", {56'd0, out_bus}, 64'hBB);
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    chk_flags("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.par", par_out, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
